// File: rtl/uart_frame_tx_pkg.sv
// Shared definitions for the UART frame encoder and its receive-side peer:
// FSM state encoding, default sync/tail bytes and checksum arithmetic.
package uart_frame_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } frame_state_e;

    localparam logic [7:0] DEF_HEADER0 = 8'h55;
    localparam logic [7:0] DEF_HEADER1 = 8'hA5;
    localparam logic [7:0] DEF_TAIL    = 8'hF0;

    localparam int CHK_W = 8;

    // Checksum accumulation step: plain modulo-2^CHK_W addition.
    function automatic logic [CHK_W-1:0] chk_add(input logic [CHK_W-1:0] acc,
                                                 input logic [7:0]       b);
        return acc + CHK_W'(b);
    endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Request/status and byte-transmitter handshake bundle for uart_frame_tx.
// master = the frame encoder, slave = the requester plus byte transmitter.
interface uart_frame_tx_if #(
    parameter int PAYLOAD_BYTES = 2
);
    logic                       start;
    logic [8*PAYLOAD_BYTES-1:0] payload;
    logic                       busy;
    logic                       frame_done;
    logic                       overrun;
    logic                       timeout_err;
    logic [7:0]                 tx_data;
    logic                       send_go;
    logic                       tx_done;

    modport master (
        input  start, payload, tx_done,
        output busy, frame_done, overrun, timeout_err, tx_data, send_go
    );

    modport slave (
        output start, payload, tx_done,
        input  busy, frame_done, overrun, timeout_err, tx_data, send_go
    );
endinterface

// File: rtl/uart_frame_byte_sel.sv
// Combinational frame byte mux: header, payload, checksum or tail by index.
module uart_frame_byte_sel
    import uart_frame_tx_pkg::*;
#(
    parameter int         PAYLOAD_BYTES = 2,
    parameter logic [7:0] HEADER0       = DEF_HEADER0,
    parameter logic [7:0] HEADER1       = DEF_HEADER1,
    parameter logic [7:0] TAIL          = DEF_TAIL,
    parameter int         IDX_W         = 3
) (
    input  logic [IDX_W-1:0]           idx,
    input  logic [8*PAYLOAD_BYTES-1:0] payload,
    output logic [7:0]                 byte_o
);

    localparam int NBYTES = PAYLOAD_BYTES + 4;

    logic [7:0]       frame_bytes [NBYTES];
    logic [CHK_W-1:0] chk_sum;

    // Sum of the latched payload bytes, wrapping at 8 bits.
    always_comb begin
        chk_sum = '0;
        for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            chk_sum = chk_add(chk_sum, payload[8*k +: 8]);
        end
    end

    assign frame_bytes[0]        = HEADER0;
    assign frame_bytes[1]        = HEADER1;
    assign frame_bytes[NBYTES-2] = chk_sum;
    assign frame_bytes[NBYTES-1] = TAIL;

    generate
        for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_payload
            assign frame_bytes[gi+2] = payload[8*gi +: 8];
        end
    endgenerate

    // Select by index; indices beyond the frame produce 00.
    always_comb begin
        byte_o = 8'h00;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx == IDX_W'(k)) begin
                byte_o = frame_bytes[k];
            end
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Frame encoder: sends HEADER0, HEADER1, payload bytes, checksum, TAIL to a
// byte transmitter over a level-held send_go / pulsed tx_done handshake,
// with one idle cycle between bytes and a per-byte ack timeout.
module uart_frame_tx
    import uart_frame_tx_pkg::*;
#(
    parameter int         PAYLOAD_BYTES  = 2,
    parameter logic [7:0] HEADER0        = DEF_HEADER0,
    parameter logic [7:0] HEADER1        = DEF_HEADER1,
    parameter logic [7:0] TAIL           = DEF_TAIL,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic            clk,
    input  logic            reset,
    uart_frame_tx_if.master bus
);

    localparam int NBYTES = PAYLOAD_BYTES + 4;
    localparam int IDX_W  = $clog2(NBYTES);
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    frame_state_e               state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;
    logic                       busy_q, busy_d;
    logic                       send_go_q, send_go_d;
    logic [7:0]                 tx_data_q, tx_data_d;
    logic                       frame_done_q, frame_done_d;
    logic                       overrun_q, overrun_d;
    logic                       timeout_err_q, timeout_err_d;

    logic [IDX_W-1:0]           sel_idx;
    logic [7:0]                 sel_byte;

    // A new byte is launched either from IDLE (always header 0) or at the
    // end of GAP (idx_q already points at the next byte).
    assign sel_idx = (state_q == ST_GAP) ? idx_q : '0;

    uart_frame_byte_sel #(
        .PAYLOAD_BYTES (PAYLOAD_BYTES),
        .HEADER0       (HEADER0),
        .HEADER1       (HEADER1),
        .TAIL          (TAIL),
        .IDX_W         (IDX_W)
    ) u_byte_sel (
        .idx     (sel_idx),
        .payload (payload_q),
        .byte_o  (sel_byte)
    );

    // Next-state, handshake and timeout logic.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        payload_d     = payload_q;
        busy_d        = busy_q;
        send_go_d     = send_go_q;
        tx_data_d     = tx_data_q;
        frame_done_d  = 1'b0;
        overrun_d     = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    payload_d = bus.payload;
                    idx_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    send_go_d = 1'b1;
                    tx_data_d = sel_byte;
                    state_d   = ST_SEND;
                end
            end

            ST_SEND: begin
                overrun_d = bus.start;
                if (bus.tx_done) begin
                    // Ack wins over a timeout expiring on the same edge.
                    send_go_d = 1'b0;
                    cnt_d     = '0;
                    if (idx_q == LAST_IDX) begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        idx_d        = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_GAP;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    send_go_d     = 1'b0;
                    busy_d        = 1'b0;
                    timeout_err_d = 1'b1;
                    idx_d         = '0;
                    cnt_d         = '0;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                overrun_d = bus.start;
                send_go_d = 1'b1;
                tx_data_d = sel_byte;
                cnt_d     = '0;
                state_d   = ST_SEND;
            end

            default: begin
                busy_d    = 1'b0;
                send_go_d = 1'b0;
                idx_d     = '0;
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            payload_q     <= '0;
            busy_q        <= 1'b0;
            send_go_q     <= 1'b0;
            tx_data_q     <= 8'h00;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            payload_q     <= payload_d;
            busy_q        <= busy_d;
            send_go_q     <= send_go_d;
            tx_data_q     <= tx_data_d;
            frame_done_q  <= frame_done_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.send_go     = send_go_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx (2 payload bytes, 100-cycle timeout).
module tb_uart_frame_tx;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_frame_tx_if #(.PAYLOAD_BYTES(2)) ifc ();

    uart_frame_tx #(
        .PAYLOAD_BYTES  (2),
        .HEADER0        (8'h55),
        .HEADER1        (8'hA5),
        .TAIL           (8'hF0),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] pl);
        ifc.start   = 1'b1;
        ifc.payload = pl;
        tick();
        ifc.start   = 1'b0;
        ifc.payload = 16'hDEAD;
    endtask

    // Entered with send_go just risen on byte 0. Acks each byte after 10
    // cycles high unless a timeout or reset scenario is selected.
    task automatic run_frame(input string tag, input logic [15:0] pl, input logic [7:0] chk,
                             input int ov_send, input int ov_gap, input int to_byte,
                             input int rst_byte, input bit chain, input logic [15:0] next_pl);
        logic [7:0] exp [6];
        exp[0] = 8'h55;
        exp[1] = 8'hA5;
        exp[2] = pl[7:0];
        exp[3] = pl[15:8];
        exp[4] = chk;
        exp[5] = 8'hF0;
        for (int b = 0; b < 6; b++) begin
            chk1($sformatf("%s.go%0d", tag, b), ifc.send_go, 1'b1);
            chk8($sformatf("%s.data%0d", tag, b), ifc.tx_data, exp[b]);
            chk1($sformatf("%s.busy%0d", tag, b), ifc.busy, 1'b1);
            $display("%s byte %0d tx_data=%h", tag, b, ifc.tx_data);
            if (b == to_byte) begin
                repeat (99) tick();
                chk1($sformatf("%s.to_hold", tag), ifc.send_go, 1'b1);
                chk1($sformatf("%s.to_early", tag), ifc.timeout_err, 1'b0);
                tick();
                chk1($sformatf("%s.to_go", tag), ifc.send_go, 1'b0);
                chk1($sformatf("%s.to_busy", tag), ifc.busy, 1'b0);
                chk1($sformatf("%s.to_err", tag), ifc.timeout_err, 1'b1);
                chk1($sformatf("%s.to_fd", tag), ifc.frame_done, 1'b0);
                tick();
                chk1($sformatf("%s.to_pulse", tag), ifc.timeout_err, 1'b0);
                return;
            end
            for (int c = 0; c < 9; c++) begin
                if (b == ov_send && c == 3) begin
                    ifc.start   = 1'b1;
                    ifc.payload = 16'hBEEF;
                    tick();
                    ifc.start   = 1'b0;
                    chk1($sformatf("%s.ov_send", tag), ifc.overrun, 1'b1);
                end else if (b == rst_byte && c == 3) begin
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    chk1($sformatf("%s.rst_go", tag), ifc.send_go, 1'b0);
                    chk1($sformatf("%s.rst_busy", tag), ifc.busy, 1'b0);
                    chk8($sformatf("%s.rst_data", tag), ifc.tx_data, 8'h00);
                    chk1($sformatf("%s.rst_fd", tag), ifc.frame_done, 1'b0);
                    chk1($sformatf("%s.rst_to", tag), ifc.timeout_err, 1'b0);
                    ifc.tx_done = 1'b1;
                    tick();
                    ifc.tx_done = 1'b0;
                    repeat (3) tick();
                    chk1($sformatf("%s.rst_ack_go", tag), ifc.send_go, 1'b0);
                    chk1($sformatf("%s.rst_ack_busy", tag), ifc.busy, 1'b0);
                    chk1($sformatf("%s.rst_ack_fd", tag), ifc.frame_done, 1'b0);
                    return;
                end else begin
                    tick();
                end
            end
            chk8($sformatf("%s.stable%0d", tag, b), ifc.tx_data, exp[b]);
            ifc.tx_done = 1'b1;
            tick();
            ifc.tx_done = 1'b0;
            chk1($sformatf("%s.low%0d", tag, b), ifc.send_go, 1'b0);
            if (b == 5) begin
                chk1($sformatf("%s.fd", tag), ifc.frame_done, 1'b1);
                chk1($sformatf("%s.fd_busy", tag), ifc.busy, 1'b0);
                if (chain) begin
                    do_start(next_pl);
                end else begin
                    tick();
                end
                chk1($sformatf("%s.fd_pulse", tag), ifc.frame_done, 1'b0);
            end else begin
                chk1($sformatf("%s.gap_busy%0d", tag, b), ifc.busy, 1'b1);
                chk1($sformatf("%s.gap_fd%0d", tag, b), ifc.frame_done, 1'b0);
                if (b == ov_gap) begin
                    ifc.start   = 1'b1;
                    ifc.payload = 16'h5A5A;
                    tick();
                    ifc.start   = 1'b0;
                    chk1($sformatf("%s.ov_gap", tag), ifc.overrun, 1'b1);
                end else begin
                    tick();
                end
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        ifc.start   = 1'b0;
        ifc.payload = 16'h0000;
        ifc.tx_done = 1'b0;
        repeat (2) tick();
        chk1("rst.busy", ifc.busy, 1'b0);
        chk1("rst.go", ifc.send_go, 1'b0);
        chk8("rst.data", ifc.tx_data, 8'h00);
        chk1("rst.fd", ifc.frame_done, 1'b0);
        chk1("rst.ov", ifc.overrun, 1'b0);
        chk1("rst.to", ifc.timeout_err, 1'b0);
        reset = 1'b0;
        tick();

        // Stray ack while idle must not start anything.
        ifc.tx_done = 1'b1;
        tick();
        ifc.tx_done = 1'b0;
        tick();
        chk1("idle_ack.busy", ifc.busy, 1'b0);
        chk1("idle_ack.go", ifc.send_go, 1'b0);

        do_start(16'h0312);
        run_frame("f0312", 16'h0312, 8'h15, -1, -1, -1, -1, 1'b0, 16'h0000);

        do_start(16'hFFFF);
        run_frame("fFFFF", 16'hFFFF, 8'hFE, -1, -1, -1, -1, 1'b0, 16'h0000);

        // Overruns in SEND (byte 2) and GAP (after byte 3), then chained start.
        do_start(16'h0000);
        run_frame("f0000", 16'h0000, 8'h00, 2, 3, -1, -1, 1'b1, 16'hA001);
        run_frame("fA001", 16'hA001, 8'hA1, -1, -1, -1, -1, 1'b0, 16'h0000);
        repeat (5) tick();
        chk1("post.go", ifc.send_go, 1'b0);
        chk1("post.busy", ifc.busy, 1'b0);

        // Withhold ack on the third byte.
        do_start(16'h0312);
        run_frame("fto", 16'h0312, 8'h15, -1, -1, 2, -1, 1'b0, 16'h0000);
        do_start(16'h0312);
        run_frame("fafter_to", 16'h0312, 8'h15, -1, -1, -1, -1, 1'b0, 16'h0000);

        // Reset while the fourth byte is in flight.
        do_start(16'h0312);
        run_frame("frst", 16'h0312, 8'h15, -1, -1, -1, 3, 1'b0, 16'h0000);
        do_start(16'h80C0);
        run_frame("fafter_rst", 16'h80C0, 8'h40, -1, -1, -1, -1, 1'b0, 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
